srt_div_arbiter: RTL

//  Shares one SRTDivider instance among NREQ requesters (ALU lanes, FPU mantissa path).

---
 rtl/srt_div_pkg.sv | 28 ++
 rtl/srt_div_arbiter_divider.sv | 111 +++++++++++
 rtl/srt_div_arbiter_rr.sv | 50 +++++
 rtl/srt_div_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/srt_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : srt_div_pkg
//  Description : Shared types and helpers for the SRT divider arbiter slice.
//                - arb_state_t : arbiter FSM state encoding
//                - idw()       : requester-index width, never below 1 bit
//                - lane_lsb()  : LSB offset of a lane in a packed lane bus
//  Revision    : 1.0  initial release
// ============================================================================
package srt_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    function automatic int idw(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/srt_div_arbiter_divider.sv
`default_nettype none
// ============================================================================
//  Module      : SRTDivider
//  Description : Iterative N-bit divider, one quotient bit per cycle on
//                operand magnitudes, sign applied to the quotient at the end.
//                Signed quotient truncates toward zero; remainder is the
//                unsigned magnitude |x| mod |y|. Divide by zero finishes on
//                the load cycle with divByZeroEx=1 and q=r=0.
//                Timing: start seen -> load, then N iterations, done rises
//                N+1 cycles after start is first sampled. done and the
//                result hold until rst.
//  Ports       : clk, rst (sync, active-high), start, is_signed,
//                x/y [N-1:0] operands, q/r [N-1:0] results, done, divByZeroEx
//  Revision    : 1.0  initial release
// ============================================================================
module SRTDivider #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         done,
    output logic         divByZeroEx
);

    localparam int             CW         = (N <= 2) ? 1 : $clog2(N);
    localparam logic [CW-1:0]  c_last_cnt = CW'(N - 1);

    logic          r_active;
    logic          r_done;
    logic          r_dbz;
    logic          r_neg_q;
    logic [CW-1:0] r_cnt;
    logic [N:0]    r_rem;
    logic [N-1:0]  r_quo;
    logic [N-1:0]  r_ymag;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_r;

    logic [N-1:0]  w_xmag;
    logic [N-1:0]  w_ymag;
    logic [N:0]    w_shift;
    logic [N:0]    w_trial;
    logic          w_ge;
    logic [N:0]    w_rem_next;
    logic [N-1:0]  w_quo_next;

    // Negating the most negative value yields the same bit pattern, which is
    // exactly its magnitude when read as unsigned.
    assign w_xmag = (is_signed && x[N-1]) ? (-x) : x;
    assign w_ymag = (is_signed && y[N-1]) ? (-y) : y;

    // Remainder stays below the divisor, so bit N of the trial difference is
    // set exactly when the subtraction would go negative.
    assign w_shift    = {r_rem[N-1:0], r_quo[N-1]};
    assign w_trial    = w_shift - {1'b0, r_ymag};
    assign w_ge       = ~w_trial[N];
    assign w_rem_next = w_ge ? w_trial : w_shift;
    assign w_quo_next = {r_quo[N-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_ymag   <= '0;
            r_q      <= '0;
            r_r      <= '0;
        end else if (!r_active && !r_done && start) begin
            if (y == '0) begin
                r_done <= 1'b1;
                r_dbz  <= 1'b1;
                r_q    <= '0;
                r_r    <= '0;
            end else begin
                r_active <= 1'b1;
                r_rem    <= '0;
                r_quo    <= w_xmag;
                r_ymag   <= w_ymag;
                r_neg_q  <= is_signed && (x[N-1] ^ y[N-1]);
                r_cnt    <= '0;
            end
        end else if (r_active) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == c_last_cnt) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
                r_q      <= r_neg_q ? (-w_quo_next) : w_quo_next;
                r_r      <= w_rem_next[N-1:0];
            end
        end
    end

    assign q           = r_q;
    assign r           = r_r;
    assign done        = r_done;
    assign divByZeroEx = r_dbz;

endmodule
`default_nettype wire

// File: rtl/srt_div_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Grants the first asserted
//                request at or after ptr, wrapping past NREQ-1 to 0.
//  Ports       : req   [NREQ-1:0] in   request vector
//                ptr   [IDW-1:0]  in   highest-priority lane this cycle
//                grant [NREQ-1:0] out  one-hot grant (all 0 when no request)
//                gidx  [IDW-1:0]  out  index of granted lane
//                any              out  at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import srt_div_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int IDW  = idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gidx,
    output logic            any
);

    // Walk offsets from the far end back towards ptr so the smallest offset
    // (highest priority) is the last one written and therefore wins.
    always_comb begin
        int w_cand;
        grant  = '0;
        gidx   = '0;
        any    = 1'b0;
        w_cand = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_cand = int'(ptr) + i;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            if (req[w_cand]) begin
                gidx = IDW'(w_cand);
                any  = 1'b1;
            end
        end
        if (any) begin
            grant[gidx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/srt_div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : srt_div_arbiter
//  Description : Shares one SRTDivider among NREQ requesters. Round-robin
//                grant with operand capture, then CLEAR -> RUN -> RESP
//                sequencing of the divider with a RUN-cycle watchdog.
//                One job in flight; one tagged response per grant.
//  Ports       : clk, rst               clock, sync active-high reset
//                req_valid/req_ready    [NREQ] request handshake (one-hot ready)
//                req_signed             [NREQ] signed-division select
//                req_x/req_y            [NREQ*N] operands, lane k at [k*N +: N]
//                rsp_valid/rsp_ready    response handshake
//                rsp_id [IDW]           lane that owns the response
//                rsp_q/rsp_r [N]        quotient / remainder magnitude
//                rsp_div_by_zero        divider flagged divide by zero
//                rsp_timeout            watchdog expired before done
//                busy                   a job is being processed
//  Revision    : 1.0  initial release
// ============================================================================
module srt_div_arbiter
    import srt_div_pkg::*;
#(
    parameter int  N       = 16,
    parameter int  NREQ    = 4,
    parameter int  TIMEOUT = 2 * N + 8,
    localparam int IDW     = idw(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_signed,
    input  logic [NREQ*N-1:0] req_x,
    input  logic [NREQ*N-1:0] req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_q,
    output logic [N-1:0]      rsp_r,
    output logic              rsp_div_by_zero,
    output logic              rsp_timeout,
    output logic              busy
);

    localparam int             WDW         = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] c_wd_limit  = WDW'(TIMEOUT);
    localparam logic [IDW-1:0] c_last_lane = IDW'(NREQ - 1);

    arb_state_t     r_state;
    arb_state_t     w_next;

    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic           r_signed;
    logic [N-1:0]   r_x;
    logic [N-1:0]   r_y;
    logic [N-1:0]   r_q;
    logic [N-1:0]   r_r;
    logic           r_dbz;
    logic           r_to;
    logic [WDW-1:0] r_wd;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gidx;
    logic            w_any;
    logic            w_wd_expired;

    logic           w_div_rst;
    logic           w_div_start;
    logic [N-1:0]   w_div_q;
    logic [N-1:0]   w_div_r;
    logic           w_div_done;
    logic           w_div_dbz;

    logic [N-1:0]   w_lane_x [NREQ];
    logic [N-1:0]   w_lane_y [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_lane
        assign w_lane_x[k] = req_x[lane_lsb(k, N) +: N];
        assign w_lane_y[k] = req_y[lane_lsb(k, N) +: N];
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .gidx  (w_gidx),
        .any   (w_any)
    );

    // Divider is held in reset everywhere but RUN, so every job starts from
    // a clean divider and a finished result cannot leak into the next job.
    assign w_div_rst    = rst | (r_state != ST_RUN);
    assign w_div_start  = (r_state == ST_RUN);
    assign w_wd_expired = (r_wd == c_wd_limit);

    SRTDivider #(
        .N (N)
    ) u_div (
        .clk         (clk),
        .rst         (w_div_rst),
        .start       (w_div_start),
        .is_signed   (r_signed),
        .x           (r_x),
        .y           (r_y),
        .q           (w_div_q),
        .r           (w_div_r),
        .done        (w_div_done),
        .divByZeroEx (w_div_dbz)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_any)                       w_next = ST_CLEAR;
            ST_CLEAR:                                  w_next = ST_RUN;
            ST_RUN:   if (w_div_done || w_wd_expired)  w_next = ST_RESP;
            ST_RESP:  if (rsp_ready)                   w_next = ST_IDLE;
            default:                                   w_next = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // req_ready is masked during reset so no requester sees an accept that
    // the reset branch of the datapath would discard.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = (r_state != ST_IDLE);
        if ((r_state == ST_IDLE) && !rst) begin
            req_ready = w_grant;
        end
        if (r_state == ST_RESP) begin
            rsp_valid = 1'b1;
        end
    end

    // ---------------- job latch, watchdog, result capture ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_signed <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_dbz    <= 1'b0;
            r_to     <= 1'b0;
            r_wd     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_id     <= w_gidx;
                        r_signed <= req_signed[w_gidx];
                        r_x      <= w_lane_x[w_gidx];
                        r_y      <= w_lane_y[w_gidx];
                        r_ptr    <= (w_gidx == c_last_lane) ? '0 : (w_gidx + IDW'(1));
                    end
                end
                ST_CLEAR: begin
                    r_wd <= '0;
                end
                ST_RUN: begin
                    // done takes priority over a watchdog expiring the same cycle
                    if (w_div_done) begin
                        r_q   <= w_div_q;
                        r_r   <= w_div_r;
                        r_dbz <= w_div_dbz;
                        r_to  <= 1'b0;
                    end else if (w_wd_expired) begin
                        r_q   <= '0;
                        r_r   <= '0;
                        r_dbz <= 1'b0;
                        r_to  <= 1'b1;
                    end else begin
                        r_wd <= r_wd + WDW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_id          = r_id;
    assign rsp_q           = r_q;
    assign rsp_r           = r_r;
    assign rsp_div_by_zero = r_dbz;
    assign rsp_timeout     = r_to;

endmodule
`default_nettype wire
